// File: rtl/imem_load_arbiter.sv
// Instruction RAM owner: arbitrates between a byte-stream program loader
// and the CPU fetch path (registered fetch, little-endian word assembly).
module imem_load_arbiter #(
  parameter int          DEPTH = 64,
  parameter int          AW    = 6,
  parameter logic [31:0] NOP   = 32'hE1A00000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  input  logic          ld_last,
  output logic          ld_ready,
  input  logic          cpu_req,
  input  logic [31:0]   cpu_addr,
  output logic [31:0]   cpu_instr,
  output logic          cpu_valid,
  output logic          cpu_stall,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [31:0]   mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [31:0]   mem_rdata,
  output logic [AW:0]   loaded_words,
  output logic          err_ovf,
  output logic          err_fetch
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN
  } state_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  idx_q;
  logic [AW:0] wcnt_q;
  logic [31:0] asm_q;
  logic        last_q;
  logic [AW:0] lw_q;
  logic        ovf_q;
  logic        ferr_q;
  logic        cvalid_q;
  logic [31:0] cinstr_q;

  logic accept;
  logic full;
  logic fault;
  logic start;

  assign accept = ld_valid && ld_ready;
  assign full   = (wcnt_q == FULL);
  assign fault  = (cpu_addr[1:0] != 2'b00) ||
                  (cpu_addr[31:2] >= 30'(lw_q));
  assign start  = load_start &&
                  ((state_q == IDLE) || (state_q == RUN));

  assign mem_raddr    = cpu_addr[AW+1:2];
  assign cpu_instr    = cinstr_q;
  assign cpu_valid    = cvalid_q;
  assign loaded_words = lw_q;
  assign err_ovf      = ovf_q;
  assign err_fetch    = ferr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_ready  = 1'b0;
    cpu_stall = 1'b1;
    mem_we    = 1'b0;
    mem_waddr = wcnt_q[AW-1:0];
    mem_wdata = asm_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) state_d = LOAD;
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (accept) begin
          if (full) begin
            if (ld_last) state_d = RUN;
          end else if (ld_last || idx_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_we  = 1'b1;
        state_d = last_q ? RUN : LOAD;
      end
      RUN: begin
        cpu_stall = load_start;
        if (load_start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q    <= '0;
      wcnt_q   <= '0;
      asm_q    <= '0;
      last_q   <= 1'b0;
      lw_q     <= '0;
      ovf_q    <= 1'b0;
      ferr_q   <= 1'b0;
      cvalid_q <= 1'b0;
      cinstr_q <= '0;
    end else begin
      cvalid_q <= 1'b0;
      if (start) begin
        idx_q  <= '0;
        wcnt_q <= '0;
        asm_q  <= '0;
        last_q <= 1'b0;
        ovf_q  <= 1'b0;
      end
      if (state_q == LOAD && accept) begin
        if (full) begin
          // ram is full: consume and drop the byte
          ovf_q <= 1'b1;
          if (ld_last) lw_q <= wcnt_q;
        end else begin
          asm_q[{idx_q, 3'b000} +: 8] <= ld_byte;
          idx_q  <= idx_q + 2'd1;
          last_q <= ld_last;
        end
      end
      if (state_q == WRITE) begin
        wcnt_q <= wcnt_q + 1'b1;
        idx_q  <= '0;
        asm_q  <= '0;
        if (last_q) lw_q <= wcnt_q + 1'b1;
      end
      if (state_q == RUN && !load_start && cpu_req) begin
        cvalid_q <= 1'b1;
        cinstr_q <= fault ? NOP : mem_rdata;
        if (fault) ferr_q <= 1'b1;
      end
    end
  end

endmodule
